// File: rtl/cache_mem_arbiter.sv
// Shares one word-wide memory port between icache/dcache refill reads and a
// one-entry dcache victim write buffer. Lines are moved as four single-word
// memory transactions; read data is forwarded to the owning cache per beat.
module cache_mem_arbiter (
  input  logic         clk_g,
  input  logic         reset,
  input  logic         i_rd_req,
  input  logic [2:0]   i_rd_type,
  input  logic [31:0]  i_rd_addr,
  output logic         i_rd_rdy,
  output logic         i_ret_valid,
  output logic         i_ret_last,
  output logic [31:0]  i_ret_data,
  input  logic         d_rd_req,
  input  logic [2:0]   d_rd_type,
  input  logic [31:0]  d_rd_addr,
  output logic         d_rd_rdy,
  output logic         d_ret_valid,
  output logic         d_ret_last,
  output logic [31:0]  d_ret_data,
  input  logic         d_wr_req,
  input  logic [2:0]   d_wr_type,
  input  logic [31:0]  d_wr_addr,
  input  logic [3:0]   d_wr_wstrb,
  input  logic [127:0] d_wr_data,
  output logic         d_wr_rdy,
  output logic         mem_req,
  output logic         mem_wr,
  output logic [1:0]   mem_size,
  output logic [31:0]  mem_addr,
  output logic [3:0]   mem_wstrb,
  output logic [31:0]  mem_wdata,
  input  logic         mem_addr_ok,
  input  logic         mem_data_ok,
  input  logic [31:0]  mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_DATA} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;

  state_e       state_q, state_d;
  owner_e       owner_q, owner_d;
  owner_e       last_grant_q, last_grant_d;
  logic [2:0]   type_q, type_d;
  logic [31:0]  addr_q, addr_d;
  logic [1:0]   beat_q, beat_d;

  logic         wb_valid_q;
  logic [31:0]  wb_addr_q;
  logic [2:0]   wb_type_q;
  logic [3:0]   wb_wstrb_q;
  logic [127:0] wb_data_q;

  logic wb_capture, wb_drain_done;
  logic i_elig, d_elig, i_hit, d_hit;
  logic rd_line, rd_last, wr_line, wr_last, rd_beat_done;

  // A read hits the buffer if it targets the buffered line, or the line being
  // captured this very cycle (so it cannot slip past its own write-back).
  always_comb begin
    wb_capture = d_wr_req & ~wb_valid_q;
    i_hit = (wb_valid_q & (i_rd_addr[31:4] == wb_addr_q[31:4])) |
            (wb_capture & (i_rd_addr[31:4] == d_wr_addr[31:4]));
    d_hit = (wb_valid_q & (d_rd_addr[31:4] == wb_addr_q[31:4])) |
            (wb_capture & (d_rd_addr[31:4] == d_wr_addr[31:4]));
    i_elig  = i_rd_req & ~i_hit;
    d_elig  = d_rd_req & ~d_hit;
    rd_line = (type_q == 3'b100);
    rd_last = ~rd_line | (beat_q == 2'd3);
    wr_line = (wb_type_q == 3'b100);
    wr_last = ~wr_line | (beat_q == 2'd3);
  end

  // Next-state, arbitration and grant handshake.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    type_d        = type_q;
    addr_d        = addr_q;
    beat_d        = beat_q;
    i_rd_rdy      = 1'b0;
    d_rd_rdy      = 1'b0;
    wb_drain_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (d_elig & (~i_elig | (last_grant_q == OWN_I))) begin
          d_rd_rdy     = 1'b1;
          owner_d      = OWN_D;
          last_grant_d = OWN_D;
          type_d       = d_rd_type;
          addr_d       = d_rd_addr;
          beat_d       = 2'd0;
          state_d      = S_RD_ADDR;
        end else if (i_elig) begin
          i_rd_rdy     = 1'b1;
          owner_d      = OWN_I;
          last_grant_d = OWN_I;
          type_d       = i_rd_type;
          addr_d       = i_rd_addr;
          beat_d       = 2'd0;
          state_d      = S_RD_ADDR;
        end else if (wb_valid_q) begin
          beat_d  = 2'd0;
          state_d = S_WR_ADDR;
        end
      end
      S_RD_ADDR: if (mem_addr_ok) state_d = S_RD_DATA;
      S_RD_DATA: begin
        if (mem_data_ok) begin
          if (rd_last) state_d = S_IDLE;
          else begin
            beat_d  = beat_q + 2'd1;
            state_d = S_RD_ADDR;
          end
        end
      end
      S_WR_ADDR: if (mem_addr_ok) state_d = S_WR_DATA;
      S_WR_DATA: begin
        if (mem_data_ok) begin
          if (wr_last) begin
            wb_drain_done = 1'b1;
            state_d       = S_IDLE;
          end else begin
            beat_d  = beat_q + 2'd1;
            state_d = S_WR_ADDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Memory-port and return-path outputs decoded from the current state.
  always_comb begin
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = 2'd0;
    mem_addr     = '0;
    mem_wstrb    = '0;
    mem_wdata    = '0;
    rd_beat_done = (state_q == S_RD_DATA) & mem_data_ok;
    if (state_q == S_RD_ADDR) begin
      mem_req  = 1'b1;
      mem_size = rd_line ? 2'd2 : type_q[1:0];
      mem_addr = rd_line ? {addr_q[31:4], beat_q, 2'b00} : addr_q;
    end else if (state_q == S_WR_ADDR) begin
      mem_req   = 1'b1;
      mem_wr    = 1'b1;
      mem_size  = 2'd2;
      mem_addr  = wr_line ? {wb_addr_q[31:4], beat_q, 2'b00} : wb_addr_q;
      mem_wstrb = wb_wstrb_q;
      mem_wdata = wb_data_q[{beat_q, 5'b00000} +: 32];
    end
    i_ret_valid = rd_beat_done & (owner_q == OWN_I);
    d_ret_valid = rd_beat_done & (owner_q == OWN_D);
    i_ret_last  = i_ret_valid & rd_last;
    d_ret_last  = d_ret_valid & rd_last;
    i_ret_data  = i_ret_valid ? mem_rdata : '0;
    d_ret_data  = d_ret_valid ? mem_rdata : '0;
    d_wr_rdy    = ~wb_valid_q;
  end

  // Main FSM registers.
  always_ff @(posedge clk_g or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_I;
      last_grant_q <= OWN_I;
      type_q       <= '0;
      addr_q       <= '0;
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      type_q       <= type_d;
      addr_q       <= addr_d;
      beat_q       <= beat_d;
    end
  end

  // One-entry victim write buffer: filled on handshake, emptied by the drain.
  always_ff @(posedge clk_g or posedge reset) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_type_q  <= '0;
      wb_wstrb_q <= '0;
      wb_data_q  <= '0;
    end else if (wb_capture) begin
      wb_valid_q <= 1'b1;
      wb_addr_q  <= d_wr_addr;
      wb_type_q  <= d_wr_type;
      wb_wstrb_q <= d_wr_wstrb;
      wb_data_q  <= d_wr_data;
    end else if (wb_drain_done) begin
      wb_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: a transaction-level model
// predicts memory transactions and return beats; a responder plays memory.
module tb_cache_mem_arbiter;
  logic         clk_g = 1'b0;
  logic         reset = 1'b1;
  logic         i_rd_req = 1'b0, d_rd_req = 1'b0, d_wr_req = 1'b0;
  logic [2:0]   i_rd_type = '0, d_rd_type = '0, d_wr_type = '0;
  logic [31:0]  i_rd_addr = '0, d_rd_addr = '0, d_wr_addr = '0;
  logic [3:0]   d_wr_wstrb = '0;
  logic [127:0] d_wr_data = '0;
  logic         i_rd_rdy, i_ret_valid, i_ret_last, d_rd_rdy, d_ret_valid, d_ret_last, d_wr_rdy;
  logic [31:0]  i_ret_data, d_ret_data;
  logic         mem_req, mem_wr;
  logic [1:0]   mem_size;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic [3:0]   mem_wstrb;
  logic         mem_addr_ok, mem_data_ok;

  cache_mem_arbiter dut (
    .clk_g(clk_g), .reset(reset),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
    .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
    .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
    .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr), .d_wr_wstrb(d_wr_wstrb),
    .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk_g = ~clk_g;

  typedef struct { bit wr; bit [1:0] size; bit [31:0] addr; bit [3:0] wstrb; bit [31:0] wdata; } mtx_t;
  typedef struct { bit [31:0] data; bit last; } ret_t;

  mtx_t        exp_mem[$];
  ret_t        exp_i[$], exp_d[$];
  bit [31:0]   mem_img [bit [31:0]];
  bit [31:0]   mem_log[$], d_data_log[$];
  int          checks = 0, failures = 0, cyc = 0;
  int          i_grants = 0, d_grants = 0, i_lasts = 0, d_lasts = 0, d_beats = 0;
  int          wr_done = 0, holds = 0, stall_cfg = 0;
  int          i_grant_cyc = 0, d_grant_cyc = 0, i_last_cyc = 0, d_last_cyc = 0, wr_done_cyc = 0;
  bit          resp_wr = 0;

  initial forever begin
    @(posedge clk_g);
    cyc++;
  end

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit [31:0] mem_rd(input bit [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  // Model: a request expands into word transactions in ascending address order.
  task automatic model_read(input bit dport, input bit [2:0] typ, input bit [31:0] addr);
    mtx_t m; ret_t r; int n; bit [31:0] a;
    n = (typ == 3'b100) ? 4 : 1;
    for (int k = 0; k < n; k++) begin
      a = (n == 4) ? ((addr & 32'hFFFF_FFF0) + 32'(4 * k)) : addr;
      m.wr = 1'b0; m.size = (n == 4) ? 2'd2 : typ[1:0]; m.addr = a; m.wstrb = '0; m.wdata = '0;
      exp_mem.push_back(m);
      r.data = mem_rd(a); r.last = (k == n - 1);
      if (dport) exp_d.push_back(r); else exp_i.push_back(r);
    end
  endtask

  task automatic model_write(input bit [2:0] typ, input bit [31:0] addr, input bit [3:0] strb,
                             input bit [127:0] data);
    mtx_t m; int n;
    n = (typ == 3'b100) ? 4 : 1;
    for (int k = 0; k < n; k++) begin
      m.wr = 1'b1; m.size = 2'd2; m.wstrb = strb; m.wdata = data[32 * k +: 32];
      m.addr = (n == 4) ? ((addr & 32'hFFFF_FFF0) + 32'(4 * k)) : addr;
      exp_mem.push_back(m);
    end
  endtask

  // Memory responder: accepts an address (optionally after a stall) and
  // returns data / write completion on the following cycle.
  initial begin
    bit pending, pend_wr, holding;
    bit [31:0] pend_data;
    int stall_left;
    pending = 0; pend_wr = 0; holding = 0; pend_data = '0; stall_left = 0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk_g); #1;
      mem_data_ok = pending;
      mem_rdata   = pending ? pend_data : '0;
      resp_wr     = pending & pend_wr;
      pending     = 0;
      if (mem_req) begin
        if (!holding) stall_left = stall_cfg;
        if (stall_left > 0) begin
          stall_left--; mem_addr_ok = 1'b0; holding = 1;
        end else begin
          mem_addr_ok = 1'b1; holding = 0; pending = 1;
          pend_wr = mem_wr; pend_data = mem_rd(mem_addr);
        end
      end else begin
        mem_addr_ok = 1'b0; holding = 0;
      end
    end
  end

  // Compare process: every cycle out of reset.
  initial begin
    bit prev_req, prev_ok;
    logic [70:0] prev_bus;
    mtx_t e; ret_t r;
    prev_req = 0; prev_ok = 0; prev_bus = '0;
    forever begin
      @(negedge clk_g);
      if (reset) begin
        prev_req = 0;
      end else begin
        if (mem_req) begin
          if (prev_req && !prev_ok) begin
            holds++;
            check({mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata} == prev_bus, "mem_hold",
                  {32'd0, mem_addr}, {32'd0, prev_bus[67:36]});
          end else if (exp_mem.size() == 0) begin
            check(1'b0, "mem_unexpected", {32'd0, mem_addr}, 64'd0);
          end else begin
            e = exp_mem.pop_front();
            mem_log.push_back(mem_addr);
            check({mem_wr, mem_size, mem_addr} == {e.wr, e.size, e.addr}, "mem_txn",
                  {29'd0, mem_wr, mem_size, mem_addr}, {29'd0, e.wr, e.size, e.addr});
            if (e.wr)
              check({mem_wstrb, mem_wdata} == {e.wstrb, e.wdata}, "mem_wdata",
                    {28'd0, mem_wstrb, mem_wdata}, {28'd0, e.wstrb, e.wdata});
          end
        end
        prev_req = mem_req; prev_ok = mem_addr_ok;
        prev_bus = {mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata};
        if (mem_data_ok && resp_wr) begin wr_done++; wr_done_cyc = cyc; end
        if (i_ret_valid) begin
          if (exp_i.size() == 0) check(1'b0, "i_ret_unexpected", {32'd0, i_ret_data}, 64'd0);
          else begin
            r = exp_i.pop_front();
            check({i_ret_last, i_ret_data} == {r.last, r.data}, "i_ret",
                  {31'd0, i_ret_last, i_ret_data}, {31'd0, r.last, r.data});
          end
          if (i_ret_last) begin i_lasts++; i_last_cyc = cyc; end
        end else begin
          check(i_ret_data == '0 && !i_ret_last, "i_ret_idle", {31'd0, i_ret_last, i_ret_data}, 64'd0);
        end
        if (d_ret_valid) begin
          d_beats++; d_data_log.push_back(d_ret_data);
          if (exp_d.size() == 0) check(1'b0, "d_ret_unexpected", {32'd0, d_ret_data}, 64'd0);
          else begin
            r = exp_d.pop_front();
            check({d_ret_last, d_ret_data} == {r.last, r.data}, "d_ret",
                  {31'd0, d_ret_last, d_ret_data}, {31'd0, r.last, r.data});
          end
          if (d_ret_last) begin d_lasts++; d_last_cyc = cyc; end
        end else begin
          check(d_ret_data == '0 && !d_ret_last, "d_ret_idle", {31'd0, d_ret_last, d_ret_data}, 64'd0);
        end
        if (i_rd_rdy) begin i_grants++; i_grant_cyc = cyc; end
        if (d_rd_rdy) begin d_grants++; d_grant_cyc = cyc; end
      end
    end
  end

  // Advance one cycle, dropping any request whose handshake completed.
  task automatic cycle();
    bit di, ii, dw;
    @(negedge clk_g);
    di = d_rd_rdy; ii = i_rd_rdy; dw = d_wr_req & d_wr_rdy;
    @(posedge clk_g); #1;
    if (di) d_rd_req = 1'b0;
    if (ii) i_rd_req = 1'b0;
    if (dw) d_wr_req = 1'b0;
  endtask

  task automatic set_d_rd(input bit [2:0] t, input bit [31:0] a);
    d_rd_req = 1'b1; d_rd_type = t; d_rd_addr = a;
  endtask
  task automatic set_i_rd(input bit [2:0] t, input bit [31:0] a);
    i_rd_req = 1'b1; i_rd_type = t; i_rd_addr = a;
  endtask
  task automatic set_d_wr(input bit [2:0] t, input bit [31:0] a, input bit [3:0] s, input bit [127:0] d);
    d_wr_req = 1'b1; d_wr_type = t; d_wr_addr = a; d_wr_wstrb = s; d_wr_data = d;
  endtask

  initial begin
    int b0, b1;
    bit [127:0] wd;
    // Reset state
    @(negedge clk_g);
    check(!mem_req && !mem_wr && mem_size == 2'd0, "rst_mem_req", {61'd0, mem_req, mem_size}, 64'd0);
    check(mem_addr == '0 && mem_wdata == '0 && mem_wstrb == '0, "rst_mem_bus", {32'd0, mem_addr}, 64'd0);
    check(d_wr_rdy, "rst_d_wr_rdy", {63'd0, d_wr_rdy}, 64'd1);
    check(!i_ret_valid && !d_ret_valid && !i_rd_rdy && !d_rd_rdy, "rst_ret",
          {60'd0, i_ret_valid, d_ret_valid, i_rd_rdy, d_rd_rdy}, 64'd0);
    @(posedge clk_g); @(posedge clk_g); #1; reset = 1'b0;

    // dcache line read
    mem_img[32'h1C00_0010] = 32'hA0; mem_img[32'h1C00_0014] = 32'hA1;
    mem_img[32'h1C00_0018] = 32'hA2; mem_img[32'h1C00_001C] = 32'hA3;
    model_read(1'b1, 3'b100, 32'h1C00_0014);
    set_d_rd(3'b100, 32'h1C00_0014);
    for (int n = 0; n < 40 && d_lasts < 1; n++) cycle();
    check(d_lasts == 1, "t1_done", 64'(d_lasts), 64'd1);
    check(d_last_cyc - d_grant_cyc == 8, "t1_latency", 64'(d_last_cyc - d_grant_cyc), 64'd8);
    check(mem_log.size() == 4 && mem_log[0] == 32'h1C00_0010 && mem_log[3] == 32'h1C00_001C,
          "t1_addr", {32'd0, mem_log.size() > 3 ? mem_log[3] : 32'd0}, 64'h1C00_001C);
    check(d_data_log.size() == 4 && d_data_log[0] == 32'hA0 && d_data_log[3] == 32'hA3,
          "t1_data", {32'd0, d_data_log.size() > 3 ? d_data_log[3] : 32'd0}, 64'hA3);
    check(d_grants == 1, "t1_rdy_pulse", 64'(d_grants), 64'd1);

    // Round robin after a dcache grant: icache first
    model_read(1'b0, 3'b100, 32'h0000_0100);
    model_read(1'b1, 3'b100, 32'h0000_0200);
    set_i_rd(3'b100, 32'h0000_0100); set_d_rd(3'b100, 32'h0000_0200);
    for (int n = 0; n < 60 && d_lasts < 2; n++) cycle();
    check(i_grants == 1 && d_grants == 2, "rr_grants", 64'(i_grants * 10 + d_grants), 64'd12);
    check(d_grant_cyc - i_last_cyc == 1, "rr_regrant", 64'(d_grant_cyc - i_last_cyc), 64'd1);

    // Simultaneous requests out of reset: dcache first
    reset = 1'b1; cycle(); cycle(); reset = 1'b0;
    model_read(1'b1, 3'b100, 32'h0000_0300);
    model_read(1'b0, 3'b100, 32'h0000_0400);
    set_i_rd(3'b100, 32'h0000_0400); set_d_rd(3'b100, 32'h0000_0300);
    for (int n = 0; n < 60 && i_lasts < 2; n++) cycle();
    check(i_lasts == 2, "sim_done", 64'(i_lasts), 64'd2);
    check(d_last_cyc - d_grant_cyc == 8, "sim_d_latency", 64'(d_last_cyc - d_grant_cyc), 64'd8);
    check(i_grant_cyc - d_last_cyc == 1, "sim_i_after_d", 64'(i_grant_cyc - d_last_cyc), 64'd1);

    // Write-back then refill
    wd = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
    model_read(1'b1, 3'b100, 32'h0000_8000);
    model_write(3'b100, 32'h0000_2000, 4'hF, wd);
    b0 = wr_done;
    set_d_rd(3'b100, 32'h0000_8000); set_d_wr(3'b100, 32'h0000_2000, 4'hF, wd);
    cycle();
    check(!d_wr_rdy, "wb_rdy_fall", {63'd0, d_wr_rdy}, 64'd0);
    for (int n = 0; n < 60 && wr_done < b0 + 4; n++) cycle();
    check(wr_done == b0 + 4, "wb_drained", 64'(wr_done - b0), 64'd4);
    check(d_wr_rdy && (cyc - wr_done_cyc == 1), "wb_rdy_rise", {63'd0, d_wr_rdy}, 64'd1);

    // Read hitting the line being written back waits for the drain
    wd = {32'h3333_0003, 32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
    model_write(3'b100, 32'h0000_3000, 4'h5, wd);
    model_read(1'b1, 3'b100, 32'h0000_3008);
    b0 = wr_done; b1 = d_grants;
    set_d_rd(3'b100, 32'h0000_3008); set_d_wr(3'b100, 32'h0000_3000, 4'h5, wd);
    for (int n = 0; n < 40 && d_grants == b1; n++) cycle();
    check(d_grants == b1 + 1, "hz_granted", 64'(d_grants - b1), 64'd1);
    check(wr_done - b0 == 4, "hz_after_drain", 64'(wr_done - b0), 64'd4);
    check(d_grant_cyc - wr_done_cyc == 1, "hz_grant_time", 64'(d_grant_cyc - wr_done_cyc), 64'd1);
    b1 = d_lasts;
    for (int n = 0; n < 40 && d_lasts == b1; n++) cycle();
    check(d_lasts == b1 + 1, "hz_read_done", 64'(d_lasts - b1), 64'd1);

    // Uncached half-word read, then single-word write with address stall
    model_read(1'b0, 3'b001, 32'h0000_0002);
    b1 = i_lasts;
    set_i_rd(3'b001, 32'h0000_0002);
    for (int n = 0; n < 20 && i_lasts == b1; n++) cycle();
    check(i_lasts == b1 + 1 && i_last_cyc - i_grant_cyc == 2, "unc_rd", 64'(i_last_cyc - i_grant_cyc), 64'd2);
    wd = {32'hBAD0_0003, 32'hBAD0_0002, 32'hBAD0_0001, 32'h1122_3344};
    model_write(3'b010, 32'h0000_0044, 4'b0011, wd);
    b0 = wr_done; b1 = holds; stall_cfg = 3;
    set_d_wr(3'b010, 32'h0000_0044, 4'b0011, wd);
    for (int n = 0; n < 30 && wr_done == b0; n++) cycle();
    stall_cfg = 0;
    check(wr_done == b0 + 1, "unc_wr_done", 64'(wr_done - b0), 64'd1);
    check(holds - b1 == 3, "unc_wr_holds", 64'(holds - b1), 64'd3);
    cycle();
    check(d_wr_rdy, "unc_wr_rdy", {63'd0, d_wr_rdy}, 64'd1);

    // Reset in the middle of a burst with a write buffered
    model_read(1'b1, 3'b100, 32'h0000_5000);
    b0 = d_beats;
    set_d_rd(3'b100, 32'h0000_5000);
    set_d_wr(3'b100, 32'h0000_6000, 4'hF, {4{32'h6666_6666}});
    for (int n = 0; n < 30 && d_beats < b0 + 2; n++) cycle();
    check(d_beats == b0 + 2, "mid_two_beats", 64'(d_beats - b0), 64'd2);
    #1; reset = 1'b1;
    @(negedge clk_g);
    check(!mem_req && !d_ret_valid, "mid_rst_quiet", {62'd0, mem_req, d_ret_valid}, 64'd0);
    check(d_wr_rdy, "mid_rst_wr_rdy", {63'd0, d_wr_rdy}, 64'd1);
    exp_mem.delete(); exp_d.delete();
    @(posedge clk_g); #2; reset = 1'b0;
    @(negedge clk_g);
    check(!d_ret_valid && !i_ret_valid && !mem_req, "mid_late_dok", {62'd0, d_ret_valid, mem_req}, 64'd0);
    cycle();
    model_read(1'b0, 3'b100, 32'h0000_7000);
    b1 = i_lasts;
    set_i_rd(3'b100, 32'h0000_7000);
    for (int n = 0; n < 40 && i_lasts == b1; n++) cycle();
    check(i_lasts == b1 + 1 && i_last_cyc - i_grant_cyc == 8, "mid_after_read",
          64'(i_last_cyc - i_grant_cyc), 64'd8);
    cycle(); cycle();

    check(exp_mem.size() == 0, "end_mem_queue", 64'(exp_mem.size()), 64'd0);
    check(exp_i.size() == 0 && exp_d.size() == 0, "end_ret_queue", 64'(exp_i.size() + exp_d.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
